// File: rtl/my_network_aurora.sv
// 4x4 single-router NoC endpoint: per-(send port, VC) input queues, per-port VC
// round-robin, per-output round-robin crossbar and one-entry registered outputs.
module my_network_aurora #(
    parameter int NUM_VCS         = 2,
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    parameter int DEST_BITS       = 2,
    parameter int FW              = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
    input  logic               INIT_CLK1,
    input  logic               INIT_CLK2,
    input  logic               RESET,
    input  logic [FW-1:0]      send_ports_0_putFlit_flit_in,
    input  logic               EN_send_ports_0_putFlit,
    input  logic               EN_send_ports_0_getNonFullVCs,
    output logic [NUM_VCS-1:0] send_ports_0_getNonFullVCs,
    input  logic [FW-1:0]      send_ports_1_putFlit_flit_in,
    input  logic               EN_send_ports_1_putFlit,
    input  logic               EN_send_ports_1_getNonFullVCs,
    output logic [NUM_VCS-1:0] send_ports_1_getNonFullVCs,
    input  logic [FW-1:0]      send_ports_2_putFlit_flit_in,
    input  logic               EN_send_ports_2_putFlit,
    input  logic               EN_send_ports_2_getNonFullVCs,
    output logic [NUM_VCS-1:0] send_ports_2_getNonFullVCs,
    input  logic [FW-1:0]      send_ports_3_putFlit_flit_in,
    input  logic               EN_send_ports_3_putFlit,
    input  logic               EN_send_ports_3_getNonFullVCs,
    output logic [NUM_VCS-1:0] send_ports_3_getNonFullVCs,
    input  logic               EN_recv_ports_0_getFlit,
    output logic [FW-1:0]      recv_ports_0_getFlit,
    input  logic [NUM_VCS-1:0] recv_ports_0_putNonFullVCs_nonFullVCs,
    input  logic               EN_recv_ports_0_putNonFullVCs,
    input  logic               EN_recv_ports_1_getFlit,
    output logic [FW-1:0]      recv_ports_1_getFlit,
    input  logic [NUM_VCS-1:0] recv_ports_1_putNonFullVCs_nonFullVCs,
    input  logic               EN_recv_ports_1_putNonFullVCs,
    input  logic               EN_recv_ports_2_getFlit,
    output logic [FW-1:0]      recv_ports_2_getFlit,
    input  logic [NUM_VCS-1:0] recv_ports_2_putNonFullVCs_nonFullVCs,
    input  logic               EN_recv_ports_2_putNonFullVCs,
    input  logic               EN_recv_ports_3_getFlit,
    output logic [FW-1:0]      recv_ports_3_getFlit,
    input  logic [NUM_VCS-1:0] recv_ports_3_putNonFullVCs_nonFullVCs,
    input  logic               EN_recv_ports_3_putNonFullVCs
);
    localparam int NP       = 4;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int VC_LSB   = FLIT_DATA_WIDTH;
    localparam int DEST_LSB = FLIT_DATA_WIDTH + VC_BITS;

    logic [FW-1:0]      in_flit_s [NP];
    logic [NP-1:0]      in_en_s;
    logic [NP-1:0]      get_en_s;
    logic [NP-1:0]      mask_en_s;
    logic [NUM_VCS-1:0] mask_in_s [NP];
    logic               unused_in_s;

    logic [FW-1:0]      mem_q [NP][NUM_VCS][FIFO_DEPTH];
    logic [FW-1:0]      mem_d [NP][NUM_VCS][FIFO_DEPTH];
    logic [PW-1:0]      wr_q [NP][NUM_VCS];
    logic [PW-1:0]      wr_d [NP][NUM_VCS];
    logic [PW-1:0]      rd_q [NP][NUM_VCS];
    logic [PW-1:0]      rd_d [NP][NUM_VCS];
    logic [CW-1:0]      cnt_q [NP][NUM_VCS];
    logic [CW-1:0]      cnt_d [NP][NUM_VCS];
    logic [VC_BITS-1:0] vc_rr_q [NP];
    logic [VC_BITS-1:0] vc_rr_d [NP];
    logic [1:0]         out_rr_q [NP];
    logic [1:0]         out_rr_d [NP];
    logic [NUM_VCS-1:0] mask_q [NP];
    logic [NUM_VCS-1:0] mask_d [NP];
    logic [FW-1:0]      out_q [NP];
    logic [FW-1:0]      out_d [NP];

    logic [NP-1:0]      offer_vld_s;
    logic [VC_BITS-1:0] offer_vc_s [NP];
    logic [FW-1:0]      offer_flit_s [NP];
    logic [NP-1:0]      gnt_vld_s;
    logic [1:0]         gnt_src_s [NP];
    logic [NP-1:0]      port_deq_s;
    logic [NUM_VCS-1:0] deq_s [NP];

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    function automatic logic [VC_BITS-1:0] next_vc(input logic [VC_BITS-1:0] v);
        return (v == VC_BITS'(NUM_VCS - 1)) ? {VC_BITS{1'b0}} : v + VC_BITS'(1);
    endfunction

    assign in_flit_s[0] = send_ports_0_putFlit_flit_in;
    assign in_flit_s[1] = send_ports_1_putFlit_flit_in;
    assign in_flit_s[2] = send_ports_2_putFlit_flit_in;
    assign in_flit_s[3] = send_ports_3_putFlit_flit_in;
    assign in_en_s      = {EN_send_ports_3_putFlit, EN_send_ports_2_putFlit,
                           EN_send_ports_1_putFlit, EN_send_ports_0_putFlit};
    assign get_en_s     = {EN_recv_ports_3_getFlit, EN_recv_ports_2_getFlit,
                           EN_recv_ports_1_getFlit, EN_recv_ports_0_getFlit};
    assign mask_en_s    = {EN_recv_ports_3_putNonFullVCs, EN_recv_ports_2_putNonFullVCs,
                           EN_recv_ports_1_putNonFullVCs, EN_recv_ports_0_putNonFullVCs};
    assign mask_in_s[0] = recv_ports_0_putNonFullVCs_nonFullVCs;
    assign mask_in_s[1] = recv_ports_1_putNonFullVCs_nonFullVCs;
    assign mask_in_s[2] = recv_ports_2_putNonFullVCs_nonFullVCs;
    assign mask_in_s[3] = recv_ports_3_putNonFullVCs_nonFullVCs;
    // The credit-read strobes and the second clock carry no information here.
    assign unused_in_s  = ^{INIT_CLK2, EN_send_ports_0_getNonFullVCs, EN_send_ports_1_getNonFullVCs,
                            EN_send_ports_2_getNonFullVCs, EN_send_ports_3_getNonFullVCs};

    assign recv_ports_0_getFlit = out_q[0];
    assign recv_ports_1_getFlit = out_q[1];
    assign recv_ports_2_getFlit = out_q[2];
    assign recv_ports_3_getFlit = out_q[3];

    // Queue-full status toward the senders.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            send_ports_0_getNonFullVCs[v] = (cnt_q[0][v] != CW'(FIFO_DEPTH));
            send_ports_1_getNonFullVCs[v] = (cnt_q[1][v] != CW'(FIFO_DEPTH));
            send_ports_2_getNonFullVCs[v] = (cnt_q[2][v] != CW'(FIFO_DEPTH));
            send_ports_3_getNonFullVCs[v] = (cnt_q[3][v] != CW'(FIFO_DEPTH));
        end
    end

    // Per-port VC selection, per-output arbitration and resulting dequeues.
    always_comb begin
        logic [FW-1:0]        head_v;
        logic [DEST_BITS-1:0] dst_v;
        logic                 take_v;
        int                   vi;
        int                   ki;
        head_v = {FW{1'b0}};
        dst_v  = {DEST_BITS{1'b0}};
        take_v = 1'b0;
        vi     = 0;
        ki     = 0;
        for (int k = 0; k < NP; k++) begin
            offer_vld_s[k]  = 1'b0;
            offer_vc_s[k]   = {VC_BITS{1'b0}};
            offer_flit_s[k] = {FW{1'b0}};
            for (int o = 0; o < NUM_VCS; o++) begin
                vi     = (int'(vc_rr_q[k]) + o) % NUM_VCS;
                head_v = mem_q[k][vi][rd_q[k][vi]];
                dst_v  = head_v[DEST_LSB +: DEST_BITS];
                take_v = !offer_vld_s[k] && (cnt_q[k][vi] != {CW{1'b0}}) && mask_q[dst_v][vi]
                         && (!out_q[dst_v][FW-1] || get_en_s[dst_v]);
                offer_vld_s[k]  = offer_vld_s[k] | take_v;
                offer_vc_s[k]   = take_v ? VC_BITS'(vi) : offer_vc_s[k];
                offer_flit_s[k] = take_v ? head_v : offer_flit_s[k];
            end
        end
        for (int j = 0; j < NP; j++) begin
            gnt_vld_s[j] = 1'b0;
            gnt_src_s[j] = 2'b00;
            for (int o = 0; o < NP; o++) begin
                ki     = (int'(out_rr_q[j]) + o) % NP;
                take_v = !gnt_vld_s[j] && offer_vld_s[ki]
                         && (offer_flit_s[ki][DEST_LSB +: DEST_BITS] == DEST_BITS'(j));
                gnt_vld_s[j] = gnt_vld_s[j] | take_v;
                gnt_src_s[j] = take_v ? 2'(ki) : gnt_src_s[j];
            end
        end
        for (int k = 0; k < NP; k++) begin
            port_deq_s[k] = 1'b0;
            for (int j = 0; j < NP; j++) begin
                port_deq_s[k] = port_deq_s[k] | (gnt_vld_s[j] && (gnt_src_s[j] == 2'(k)));
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                deq_s[k][v] = port_deq_s[k] && (offer_vc_s[k] == VC_BITS'(v));
            end
        end
    end

    // Next state for queues, pointers, masks and output buffers.
    always_comb begin
        logic enq_v;
        enq_v = 1'b0;
        for (int k = 0; k < NP; k++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                // A full queue still accepts when its head leaves on the same edge.
                enq_v = in_en_s[k] && in_flit_s[k][FW-1]
                        && (in_flit_s[k][VC_LSB +: VC_BITS] == VC_BITS'(v))
                        && ((cnt_q[k][v] != CW'(FIFO_DEPTH)) || deq_s[k][v]);
                mem_d[k][v] = mem_q[k][v];
                if (enq_v) begin
                    mem_d[k][v][wr_q[k][v]] = in_flit_s[k];
                    wr_d[k][v]              = inc_ptr(wr_q[k][v]);
                end else begin
                    wr_d[k][v] = wr_q[k][v];
                end
                rd_d[k][v] = deq_s[k][v] ? inc_ptr(rd_q[k][v]) : rd_q[k][v];
                case ({enq_v, deq_s[k][v]})
                    2'b10:   cnt_d[k][v] = cnt_q[k][v] + CW'(1);
                    2'b01:   cnt_d[k][v] = cnt_q[k][v] - CW'(1);
                    default: cnt_d[k][v] = cnt_q[k][v];
                endcase
            end
            vc_rr_d[k] = port_deq_s[k] ? next_vc(offer_vc_s[k]) : vc_rr_q[k];
        end
        for (int j = 0; j < NP; j++) begin
            if (gnt_vld_s[j]) begin
                out_d[j]    = offer_flit_s[gnt_src_s[j]];
                out_rr_d[j] = gnt_src_s[j] + 2'd1;
            end else if (get_en_s[j]) begin
                out_d[j]    = {FW{1'b0}};
                out_rr_d[j] = out_rr_q[j];
            end else begin
                out_d[j]    = out_q[j];
                out_rr_d[j] = out_rr_q[j];
            end
            mask_d[j] = mask_en_s[j] ? mask_in_s[j] : mask_q[j];
        end
    end

    // Queue storage; contents are only observed through the counted pointers.
    always_ff @(posedge INIT_CLK1) begin
        mem_q <= mem_d;
    end

    // Control state registers.
    always_ff @(posedge INIT_CLK1 or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < NP; k++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    wr_q[k][v]  <= {PW{1'b0}};
                    rd_q[k][v]  <= {PW{1'b0}};
                    cnt_q[k][v] <= {CW{1'b0}};
                end
                vc_rr_q[k]  <= {VC_BITS{1'b0}};
                out_rr_q[k] <= 2'b00;
                mask_q[k]   <= {NUM_VCS{1'b0}};
                out_q[k]    <= {FW{1'b0}};
            end
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            vc_rr_q  <= vc_rr_d;
            out_rr_q <= out_rr_d;
            mask_q   <= mask_d;
            out_q    <= out_d;
        end
    end
endmodule

// File: tb/tb_my_network_aurora.sv
// Directed self-checking bench for my_network_aurora.
module tb_my_network_aurora;
    logic        clk;
    logic        rst_n;
    logic [36:0] sflit [4];
    logic [3:0]  sen;
    logic [3:0]  sgen;
    logic [1:0]  nfv [4];
    logic [3:0]  rget;
    logic [36:0] rflit [4];
    logic [1:0]  rmask [4];
    logic [3:0]  rmen;
    int          checks;
    int          errors;

    my_network_aurora dut (
        .INIT_CLK1(clk), .INIT_CLK2(clk), .RESET(rst_n),
        .send_ports_0_putFlit_flit_in(sflit[0]), .EN_send_ports_0_putFlit(sen[0]),
        .EN_send_ports_0_getNonFullVCs(sgen[0]), .send_ports_0_getNonFullVCs(nfv[0]),
        .send_ports_1_putFlit_flit_in(sflit[1]), .EN_send_ports_1_putFlit(sen[1]),
        .EN_send_ports_1_getNonFullVCs(sgen[1]), .send_ports_1_getNonFullVCs(nfv[1]),
        .send_ports_2_putFlit_flit_in(sflit[2]), .EN_send_ports_2_putFlit(sen[2]),
        .EN_send_ports_2_getNonFullVCs(sgen[2]), .send_ports_2_getNonFullVCs(nfv[2]),
        .send_ports_3_putFlit_flit_in(sflit[3]), .EN_send_ports_3_putFlit(sen[3]),
        .EN_send_ports_3_getNonFullVCs(sgen[3]), .send_ports_3_getNonFullVCs(nfv[3]),
        .EN_recv_ports_0_getFlit(rget[0]), .recv_ports_0_getFlit(rflit[0]),
        .recv_ports_0_putNonFullVCs_nonFullVCs(rmask[0]), .EN_recv_ports_0_putNonFullVCs(rmen[0]),
        .EN_recv_ports_1_getFlit(rget[1]), .recv_ports_1_getFlit(rflit[1]),
        .recv_ports_1_putNonFullVCs_nonFullVCs(rmask[1]), .EN_recv_ports_1_putNonFullVCs(rmen[1]),
        .EN_recv_ports_2_getFlit(rget[2]), .recv_ports_2_getFlit(rflit[2]),
        .recv_ports_2_putNonFullVCs_nonFullVCs(rmask[2]), .EN_recv_ports_2_putNonFullVCs(rmen[2]),
        .EN_recv_ports_3_getFlit(rget[3]), .recv_ports_3_getFlit(rflit[3]),
        .recv_ports_3_putNonFullVCs_nonFullVCs(rmask[3]), .EN_recv_ports_3_putNonFullVCs(rmen[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] mk_flit(input logic [1:0] d, input logic vc, input logic [31:0] data);
        return {1'b1, 1'b0, d, vc, data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sen   = 4'b0000;
        rget  = 4'b1111;
        rmen  = 4'b1111;
        for (int j = 0; j < 4; j++) rmask[j] = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rst_n = 1'b1;
            step();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (rflit[j] !== 37'h0) begin
                    $display("FAIL reset_getFlit%0d: got %h expected 0", j, rflit[j]);
                    errors++;
                end
                checks++;
                if (nfv[j] !== 2'b11) begin
                    $display("FAIL reset_nonfull%0d: got %b expected 11", j, nfv[j]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_single();
        sflit[0] = 37'h12_0000_000A;
        sen[0]   = 1'b1;
        step();
        sen[0] = 1'b0;
        checks++;
        if (rflit[1] !== 37'h0) begin
            $display("FAIL single_early: got %h expected 0", rflit[1]);
            errors++;
        end
        step();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rflit[j] !== ((j == 1) ? 37'h12_0000_000A : 37'h0)) begin
                $display("FAIL single_out%0d: got %h", j, rflit[j]);
                errors++;
            end
        end
        step();
        checks++;
        if (rflit[1] !== 37'h0) begin
            $display("FAIL single_consumed: got %h expected 0", rflit[1]);
            errors++;
        end
    endtask

    task automatic test_sweep();
        logic [36:0] exp_f;
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                if (s != d) begin
                    exp_f    = mk_flit(2'(d), 1'((s + d) % 2), 32'hA0 + 32'(s * 16 + d));
                    sflit[s] = exp_f;
                    sen[s]   = 1'b1;
                    step();
                    sen[s] = 1'b0;
                    step();
                    for (int j = 0; j < 4; j++) begin
                        checks++;
                        if (rflit[j] !== ((j == d) ? exp_f : 37'h0)) begin
                            $display("FAIL sweep_s%0d_d%0d_out%0d: got %h expected %h", s, d, j, rflit[j],
                                     (j == d) ? exp_f : 37'h0);
                            errors++;
                        end
                    end
                    step();
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rget[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                checks++;
                if (nfv[0] !== 2'b11) begin
                    $display("FAIL bp_not_yet_full: got %b expected 11", nfv[0]);
                    errors++;
                end
            end
            sflit[0] = mk_flit(2'd1, 1'b0, 32'(i));
            sen[0]   = 1'b1;
            step();
        end
        checks++;
        if (nfv[0] !== 2'b10) begin
            $display("FAIL bp_full: got %b expected 10", nfv[0]);
            errors++;
        end
        sflit[0] = mk_flit(2'd1, 1'b0, 32'd6);
        step();
        sen[0] = 1'b0;
        checks++;
        if (rflit[1] !== mk_flit(2'd1, 1'b0, 32'd1)) begin
            $display("FAIL bp_held: got %h expected flit 1", rflit[1]);
            errors++;
        end
        checks++;
        if (nfv[0] !== 2'b10) begin
            $display("FAIL bp_drop_full: got %b expected 10", nfv[0]);
            errors++;
        end
        rget[1] = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            step();
            checks++;
            if (rflit[1] !== mk_flit(2'd1, 1'b0, 32'(i))) begin
                $display("FAIL bp_drain%0d: got %h expected %h", i, rflit[1], mk_flit(2'd1, 1'b0, 32'(i)));
                errors++;
            end
        end
        checks++;
        if (nfv[0] !== 2'b11) begin
            $display("FAIL bp_nonfull_back: got %b expected 11", nfv[0]);
            errors++;
        end
        step();
        checks++;
        if (rflit[1] !== 37'h0) begin
            $display("FAIL bp_sixth_dropped: got %h expected 0", rflit[1]);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        int order [6];
        int seq [6];
        order = '{0, 2, 3, 0, 2, 3};
        seq   = '{1, 1, 1, 2, 2, 2};
        for (int r = 1; r <= 2; r++) begin
            sflit[0] = mk_flit(2'd0, 1'b0, 32'(16 * 0 + r));
            sflit[2] = mk_flit(2'd0, 1'b0, 32'(16 * 2 + r));
            sflit[3] = mk_flit(2'd0, 1'b0, 32'(16 * 3 + r));
            sen      = 4'b1101;
            step();
        end
        sen = 4'b0000;
        for (int g = 0; g < 6; g++) begin
            checks++;
            if (rflit[0] !== mk_flit(2'd0, 1'b0, 32'(16 * order[g] + seq[g]))) begin
                $display("FAIL rr_grant%0d: got %h expected src %0d seq %0d", g, rflit[0], order[g], seq[g]);
                errors++;
            end
            step();
        end
        checks++;
        if (rflit[0] !== 37'h0) begin
            $display("FAIL rr_empty: got %h expected 0", rflit[0]);
            errors++;
        end
    endtask

    task automatic test_mask_and_reset();
        logic [36:0] f;
        f        = mk_flit(2'd2, 1'b1, 32'h0000_C0DE);
        rmask[2] = 2'b01;
        step();
        sflit[1] = f;
        sen[1]   = 1'b1;
        step();
        sen[1] = 1'b0;
        step();
        step();
        checks++;
        if (rflit[2] !== 37'h0) begin
            $display("FAIL mask_blocked: got %h expected 0", rflit[2]);
            errors++;
        end
        checks++;
        if (nfv[1] !== 2'b11) begin
            $display("FAIL mask_queue_nonfull: got %b expected 11", nfv[1]);
            errors++;
        end
        rmask[2] = 2'b10;
        rget[2]  = 1'b0;
        step();
        checks++;
        if (rflit[2] !== 37'h0) begin
            $display("FAIL mask_load_edge: got %h expected 0", rflit[2]);
            errors++;
        end
        sflit[0] = mk_flit(2'd3, 1'b0, 32'h0000_BEEF);
        sen[0]   = 1'b1;
        step();
        checks++;
        if (rflit[2] !== f) begin
            $display("FAIL mask_delivered: got %h expected %h", rflit[2], f);
            errors++;
        end
        step();
        checks++;
        if (rflit[3] !== mk_flit(2'd3, 1'b0, 32'h0000_BEEF)) begin
            $display("FAIL stream_out3: got %h", rflit[3]);
            errors++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rflit[j] !== 37'h0) begin
                $display("FAIL async_reset_out%0d: got %h expected 0", j, rflit[j]);
                errors++;
            end
            checks++;
            if (nfv[j] !== 2'b11) begin
                $display("FAIL async_reset_nonfull%0d: got %b expected 11", j, nfv[j]);
                errors++;
            end
        end
        sen = 4'b0000;
        step();
        step();
        rst_n    = 1'b1;
        rget     = 4'b1111;
        rmask[2] = 2'b11;
        step();
        step();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rflit[j] !== 37'h0) begin
                $display("FAIL post_reset_out%0d: got %h expected 0", j, rflit[j]);
                errors++;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sen    = 4'b0000;
        sgen   = 4'b1111;
        rget   = 4'b1111;
        rmen   = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            sflit[j] = 37'h0;
            rmask[j] = 2'b11;
        end
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_reset();
        test_round_robin();
        test_mask_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
